dw_cmp_dx_ser: RTL

- Digit-serial, multi-cycle duplex comparator, the serial counterpart of the team's parallel duplex comparator.
- Operands a and b arrive LSB-digit first over a valid/ready stream; after the last digit the block returns the same eq/lt/gt result set.
  - Simplex mode (dplx=0): one width-bit comparison.
  - Duplex mode (dplx=1): two comparisons, p1_width LSBs and (width-p1_width) MSBs.
- Used where operands are serialised from narrow datapaths and a full-width comparator is too costly.

---
 rtl/dw_cmp_dx_ser_pkg.sv | 29 ++
 rtl/dw_cmp_dx_ser_dig.sv | 38 +++
 rtl/dw_cmp_dx_ser.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dw_cmp_dx_ser_pkg.sv
// Shared state encoding, result record and sizing helpers for the digit-serial duplex comparator.
package dw_cmp_dx_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } res_t;

  function automatic int n_dig(input int width, input int digit_width);
    return width / digit_width;
  endfunction

  function automatic int p1_dig(input int p1_width, input int digit_width);
    return p1_width / digit_width;
  endfunction

  // Digit counter width, clog2(N_DIG), kept at least 1 bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dw_cmp_dx_ser_dig.sv
// Combinational digit step: folds one digit pair into the running eq/lt state, with sign fix.
module dw_cmp_dx_ser_dig
  import dw_cmp_dx_ser_pkg::*;
#(
  parameter int digit_width = 4
) (
  input  logic [digit_width-1:0] a_dig,
  input  logic [digit_width-1:0] b_dig,
  input  logic                   run_eq,
  input  logic                   run_lt,
  input  logic                   sign_fix_en,
  input  logic                   tc,
  output logic                   eq_next,
  output logic                   lt_next
);

  logic a_msb;
  logic b_msb;

  assign a_msb = a_dig[digit_width-1];
  assign b_msb = b_dig[digit_width-1];

  always_comb begin
    eq_next = run_eq;
    lt_next = run_lt;
    // A higher differing digit overrides whatever lower digits decided.
    if (a_dig != b_dig) begin
      eq_next = 1'b0;
      lt_next = (a_dig < b_dig);
    end
    // On a segment's top digit in signed mode, differing sign bits decide outright.
    if (sign_fix_en && tc && (a_msb != b_msb)) begin
      eq_next = 1'b0;
      lt_next = a_msb;
    end
  end

endmodule

// File: rtl/dw_cmp_dx_ser.sv
// Digit-serial simplex/duplex comparator; optional abort input under DW_CMP_DX_SER_ABORT_EN.
module dw_cmp_dx_ser
  import dw_cmp_dx_ser_pkg::*;
#(
  parameter int width       = 16,
  parameter int p1_width    = 8,
  parameter int digit_width = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   tc,
  input  logic                   dplx,
`ifdef DW_CMP_DX_SER_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [digit_width-1:0] a_dig,
  input  logic [digit_width-1:0] b_dig,
  output logic                   busy,
  output logic                   done,
  output logic                   eq1,
  output logic                   lt1,
  output logic                   gt1,
  output logic                   eq2,
  output logic                   lt2,
  output logic                   gt2
);

  localparam int N_DIG  = n_dig(width, digit_width);
  localparam int P1_DIG = p1_dig(p1_width, digit_width);
  localparam int CNT_W  = cnt_width(N_DIG);
  localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(P1_DIG - 1);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(N_DIG - 1);

  if ((digit_width < 1) || (p1_width < digit_width) || (p1_width >= width) ||
      ((p1_width % digit_width) != 0) || (((width - p1_width) % digit_width) != 0))
  begin : g_bad_param
    $error("dw_cmp_dx_ser: digit_width must divide both p1_width and width-p1_width");
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tc_reg, tc_next;
  logic             dplx_reg, dplx_next;
  logic             run_eq_reg, run_eq_next;
  logic             run_lt_reg, run_lt_next;
  res_t             res1_reg, res1_next;
  res_t             res2_reg, res2_next;

  logic abort_int;
  logic xfer;
  logic p1_hit;
  logic last_hit;
  logic step_eq;
  logic step_lt;

`ifdef DW_CMP_DX_SER_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = 1'b0;
`endif

  assign xfer     = in_valid && (state_reg == RUN);
  assign p1_hit   = dplx_reg && (cnt_reg == P1_LAST);
  assign last_hit = (cnt_reg == N_LAST);

  dw_cmp_dx_ser_dig #(
    .digit_width (digit_width)
  ) u_dig (
    .a_dig       (a_dig),
    .b_dig       (b_dig),
    .run_eq      (run_eq_reg),
    .run_lt      (run_lt_reg),
    .sign_fix_en (p1_hit || last_hit),
    .tc          (tc_reg),
    .eq_next     (step_eq),
    .lt_next     (step_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      tc_reg     <= 1'b0;
      dplx_reg   <= 1'b0;
      run_eq_reg <= 1'b1;
      run_lt_reg <= 1'b0;
      res1_reg   <= '0;
      res2_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tc_reg     <= tc_next;
      dplx_reg   <= dplx_next;
      run_eq_reg <= run_eq_next;
      run_lt_reg <= run_lt_next;
      res1_reg   <= res1_next;
      res2_reg   <= res2_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tc_next     = tc_reg;
    dplx_next   = dplx_reg;
    run_eq_next = run_eq_reg;
    run_lt_next = run_lt_reg;
    res1_next   = res1_reg;
    res2_next   = res2_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          cnt_next    = '0;
          tc_next     = tc;
          dplx_next   = dplx;
          run_eq_next = 1'b1;
          run_lt_next = 1'b0;
          res1_next   = '0;
          res2_next   = '0;
        end
      end
      RUN: begin
        if (abort_int) begin
          state_next = IDLE;
          res1_next  = '0;
          res2_next  = '0;
        end else if (xfer) begin
          cnt_next    = cnt_reg + 1'b1;
          run_eq_next = step_eq;
          run_lt_next = step_lt;
          // Part 1 closes here; part 2 starts from a fresh "equal" state.
          if (p1_hit) begin
            res1_next   = '{eq: step_eq, lt: step_lt, gt: ~step_eq & ~step_lt};
            run_eq_next = 1'b1;
            run_lt_next = 1'b0;
          end
          if (last_hit) begin
            res2_next  = '{eq: step_eq, lt: step_lt, gt: ~step_eq & ~step_lt};
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (abort_int) begin
          res1_next = '0;
          res2_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state_reg == RUN);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE) && !abort_int;
  assign eq1      = res1_reg.eq;
  assign lt1      = res1_reg.lt;
  assign gt1      = res1_reg.gt;
  assign eq2      = res2_reg.eq;
  assign lt2      = res2_reg.lt;
  assign gt2      = res2_reg.gt;

endmodule
